// File: rtl/alu_mdu.sv
// EX-stage integer ALU with iterative RV32M multiply/divide behind a valid/ready handshake.
// Latency: base ops 1 cycle, M ops DATA_WIDTH+1 cycles from accept; every result is registered.
// Backpressure: result held in DONE until out_ready; no accept until IDLE; flush aborts anything in flight.
module alu_mdu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5,
    parameter int SHAMT_WIDTH   = $clog2(DATA_WIDTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;

    logic          rdy_en;
    logic          accept, is_m;
    logic [W-1:0]  hi_q, lo_q, b_q, spec_res_q;
    logic          neg_q, neg_r, spec_q;
    logic [2:0]    mop_q;
    logic [CW-1:0] cnt_q;

    assign in_ready  = rdy_en && (state_q == IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign is_m      = (Operation[4:3] == 2'b10);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    // Base ALU
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [W-1:0]           base_res;
    assign shamt = SrcB[SHAMT_WIDTH-1:0];

    always_comb begin
        base_res = '0;
        case (Operation)
            5'b00000: base_res = SrcA & SrcB;
            5'b00001: base_res = SrcA - SrcB;
            5'b00010: base_res = SrcA + SrcB;
            5'b00011: base_res = SrcA << shamt;
            5'b00100: base_res = SrcA >> shamt;
            5'b00101: base_res = $unsigned($signed(SrcA) >>> shamt);
            5'b00110: base_res = SrcA ^ SrcB;
            5'b00111: base_res = SrcA | SrcB;
            5'b01000: base_res = {{(W-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            5'b01001: base_res = {{(W-1){1'b0}}, (SrcA == SrcB)};
            5'b01010: base_res = {{(W-1){1'b0}}, (SrcA < SrcB)};
            default:  base_res = '0;
        endcase
    end

    // Operand preparation at accept: magnitudes, result signs, divide corner cases
    logic         sgn_a, sgn_b, a_neg, b_neg, dz, ovf;
    logic [W-1:0] mag_a, mag_b, spec_val;

    always_comb begin
        sgn_a    = Operation[2] ? !Operation[0] : (Operation[1:0] == 2'b01 || Operation[1:0] == 2'b10);
        sgn_b    = Operation[2] ? !Operation[0] : (Operation[1:0] == 2'b01);
        a_neg    = sgn_a && SrcA[W-1];
        b_neg    = sgn_b && SrcB[W-1];
        mag_a    = a_neg ? -SrcA : SrcA;
        mag_b    = b_neg ? -SrcB : SrcB;
        dz       = (SrcB == '0);
        ovf      = sgn_a && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        spec_val = Operation[1] ? (dz ? SrcA : '0) : (dz ? '1 : SrcA);
    end

    // One radix-2 step: hi/lo is the product for multiply, remainder/quotient for divide
    logic [W:0]     mul_sum, div_sh;
    logic [W-1:0]   div_tr, hi_n, lo_n;
    logic           div_ge;
    logic [2*W-1:0] prod, prod_f;
    logic [W-1:0]   m_res;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
        div_sh  = {hi_q, lo_q[W-1]};
        div_ge  = (div_sh >= {1'b0, b_q});
        div_tr  = div_sh[W-1:0] - b_q;
        if (mop_q[2]) begin
            hi_n = div_ge ? div_tr : div_sh[W-1:0];
            lo_n = {lo_q[W-2:0], div_ge};
        end else begin
            hi_n = mul_sum[W:1];
            lo_n = {mul_sum[0], lo_q[W-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_f = neg_q ? -prod : prod;
        if (spec_q)
            m_res = spec_res_q;
        else if (mop_q[2])
            m_res = mop_q[1] ? (neg_r ? -hi_n : hi_n) : (neg_q ? -lo_n : lo_n);
        else
            m_res = (mop_q[1:0] == 2'b00) ? prod_f[W-1:0] : prod_f[2*W-1:W];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_m ? CALC : DONE;
            CALC:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rdy_en  <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_en  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q       <= '0;
            lo_q       <= '0;
            b_q        <= '0;
            spec_res_q <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            spec_q     <= 1'b0;
            mop_q      <= '0;
            cnt_q      <= '0;
            ALUResult  <= '0;
        end else if (accept) begin
            if (is_m) begin
                hi_q       <= '0;
                lo_q       <= mag_a;
                b_q        <= mag_b;
                mop_q      <= Operation[2:0];
                neg_q      <= a_neg ^ b_neg;
                neg_r      <= a_neg;
                spec_q     <= Operation[2] && (dz || ovf);
                spec_res_q <= spec_val;
                cnt_q      <= CW'(W);
            end else begin
                ALUResult <= base_res;
            end
        end else if (state_q == CALC && !flush) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1))
                ALUResult <= m_res;
        end
    end
endmodule
